// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W register file with zero register, write bypass and clear sweep
`timescale 1ns/1ps

module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic                  Clear,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_d;

  // Sweep/idle controller: Reset always (re)starts a sweep from entry 0, Clear only starts one from idle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_SWEEP: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          if (Clear) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Single array write port, shared between the sweep (zero fill) and writeback; Reset leaves contents alone
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = WriteRegister;
    wr_data_d = WriteData;
    if (!Reset) begin
      if (state_q == ST_SWEEP) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
      end else if (!Clear && RegWrite && !(ZERO_REG && (WriteRegister == '0))) begin
        wr_en_d = 1'b1;
      end
    end
  end

  // Storage array update
  always_ff @(posedge Clk) begin
    if (wr_en_d) begin
      mem_q[wr_addr_d] <= wr_data_d;
    end
  end

  // Read priority: sweeping, hard zero, same-cycle forward, stored value
  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    if (busy_q) begin
      return '0;
    end else if (ZERO_REG && (addr == '0)) begin
      return '0;
    end else if (BYPASS && RegWrite && !Clear && (WriteRegister == addr)) begin
      return WriteData;
    end else begin
      return mem_q[addr];
    end
  endfunction

  // Two independent combinational read ports
  always_comb begin
    ReadData1 = read_port(ReadRegister1);
    ReadData2 = read_port(ReadRegister2);
  end

  assign Busy = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - scoreboard bench for regfile_param with default and narrow/no-bypass instances
`timescale 1ns/1ps

module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        clr;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;

  logic [31:0] rd1_a, rd2_a;
  logic        busy_a_o;
  logic [15:0] rd1_b, rd2_b;
  logic        busy_b_o;

  always #5 clk = ~clk;

  regfile_param dut_a (
    .Clk           (clk),
    .Reset         (rst),
    .ReadRegister1 (ra1),
    .ReadRegister2 (ra2),
    .WriteRegister (wa),
    .WriteData     (wd),
    .RegWrite      (we),
    .Clear         (clr),
    .ReadData1     (rd1_a),
    .ReadData2     (rd2_a),
    .Busy          (busy_a_o)
  );

  regfile_param #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (3),
    .ZERO_REG   (1'b0),
    .BYPASS     (1'b0)
  ) dut_b (
    .Clk           (clk),
    .Reset         (rst),
    .ReadRegister1 (ra1[2:0]),
    .ReadRegister2 (ra2[2:0]),
    .WriteRegister (wa[2:0]),
    .WriteData     (wd[15:0]),
    .RegWrite      (we),
    .Clear         (clr),
    .ReadData1     (rd1_b),
    .ReadData2     (rd2_b),
    .Busy          (busy_b_o)
  );

  // reference model: contents plus "edges of sweep still to go"
  logic [31:0] ma [32];
  logic [15:0] mb [8];
  bit          busy_a, busy_b;
  int          left_a, left_b;
  bit          model_valid = 0;

  typedef struct {
    int          id;
    logic [31:0] a1, a2;
    logic        ab;
    logic [15:0] b1, b2;
    logic        bb;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vec_id = 0;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] exp_a(input logic [4:0] a);
    if (busy_a) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && !clr && wa == a) return wd;
    return ma[a];
  endfunction

  function automatic logic [15:0] exp_b(input logic [2:0] a);
    if (busy_b) return 16'h0;
    return mb[a];
  endfunction

  task automatic apply_edge();
    if (rst) begin
      busy_a = 1; left_a = 32;
      busy_b = 1; left_b = 8;
      foreach (ma[i]) ma[i] = 32'h0;
      foreach (mb[i]) mb[i] = 16'h0;
    end else begin
      if (busy_a) begin
        left_a--;
        if (left_a == 0) busy_a = 0;
      end else if (clr) begin
        busy_a = 1; left_a = 32;
        foreach (ma[i]) ma[i] = 32'h0;
      end else if (we && wa != 5'd0) begin
        ma[wa] = wd;
      end
      if (busy_b) begin
        left_b--;
        if (left_b == 0) busy_b = 0;
      end else if (clr) begin
        busy_b = 1; left_b = 8;
        foreach (mb[i]) mb[i] = 16'h0;
      end else if (we) begin
        mb[wa[2:0]] = wd[15:0];
      end
    end
  endtask

  task automatic cycle();
    exp_t e;
    if (model_valid) begin
      e.id = vec_id;
      vec_id++;
      e.a1 = exp_a(ra1);
      e.a2 = exp_a(ra2);
      e.ab = busy_a;
      e.b1 = exp_b(ra1[2:0]);
      e.b2 = exp_b(ra2[2:0]);
      e.bb = busy_b;
      q.push_back(e);
    end
    @(posedge clk);
    apply_edge();
    if (rst) model_valid = 1;
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; we = 0; clr = 0; wa = 0; wd = 0;
  endtask

  // monitor: compares the DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      vectors++;
      if (rd1_a !== mon_e.a1 || rd2_a !== mon_e.a2 || busy_a_o !== mon_e.ab ||
          rd1_b !== mon_e.b1 || rd2_b !== mon_e.b2 || busy_b_o !== mon_e.bb) begin
        miscompares++;
        $display("FAIL vec%0d rd/busy: got A=%h,%h,%b B=%h,%h,%b required A=%h,%h,%b B=%h,%h,%b",
                 mon_e.id, rd1_a, rd2_a, busy_a_o, rd1_b, rd2_b, busy_b_o,
                 mon_e.a1, mon_e.a2, mon_e.ab, mon_e.b1, mon_e.b2, mon_e.bb);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    ra1 = 0; ra2 = 0;
    rst = 1;
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 0;
    // reset sweep, then read every address
    for (int i = 0; i < 33; i++) begin
      ra1 = 5'($urandom); ra2 = 5'($urandom);
      cycle();
    end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      cycle();
    end
    // basic writes and the zero register
    we = 1; wa = 5;  wd = 32'hDEADBEEF; cycle();
    wa = 31; wd = 32'h12345678; cycle();
    we = 0; ra1 = 5; ra2 = 31; cycle();
    if (rd1_a !== 32'hDEADBEEF || rd2_a !== 32'h12345678) begin
      miscompares++;
      $display("FAIL directed A read: got %h,%h required DEADBEEF,12345678", rd1_a, rd2_a);
    end
    if (rd1_b !== 16'hBEEF || rd2_b !== 16'h5678) begin
      miscompares++;
      $display("FAIL directed B read: got %h,%h required BEEF,5678", rd1_b, rd2_b);
    end
    we = 1; wa = 0; wd = 32'hFFFFFFFF; ra1 = 0; ra2 = 0; cycle();
    we = 0; cycle();
    we = 1; wa = 0; wd = 32'h0000BEEF; cycle();
    we = 0; cycle();
    // same-cycle forward (A) versus old value (B)
    we = 1; wa = 7; wd = 32'hA5A5A5A5; ra1 = 7; ra2 = 7; cycle();
    we = 0; cycle();
    // clear wins over a simultaneous write; writes during sweep are ignored
    we = 1; clr = 1; wa = 3; wd = 32'h55; ra1 = 3; ra2 = 3; cycle();
    clr = 0;
    for (int i = 0; i < 33; i++) begin
      we = 1'($urandom); wa = 5'($urandom); wd = $urandom;
      ra1 = 5'($urandom); ra2 = 3;
      cycle();
    end
    we = 0; ra1 = 3; cycle();
    // reset in the middle of a sweep restarts it
    clr = 1; cycle();
    clr = 0;
    for (int i = 0; i < 9; i++) cycle();
    rst = 1; cycle();
    rst = 0;
    for (int i = 0; i < 34; i++) begin
      ra1 = 5'($urandom); ra2 = 5'($urandom);
      cycle();
    end
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      clr = ($urandom_range(0, 149) == 0);
      we  = 1'($urandom);
      wa  = 5'($urandom);
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      cycle();
    end
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    if (vectors == 0) begin
      $display("FAIL vectors: got 0 compared, required at least 1");
    end
    if (miscompares != 0) begin
      $display("FAIL summary: got %0d miscompares, required 0", miscompares);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
